nlc_fmt_converter: RTL and testbench

Pipelined bidirectional number-format converter for the NLC datapath. Converts 21-bit sign-magnitude ADC samples to IEEE-754 FP32 for the normalization/polynomial engine, and converts final FP32 results back to 21-bit sign-magnitude for the `chN_x_lin` outputs. It responds to the controller's `srdyi`/`srdyo` valid handshake. It accepts one conversion per cycle, in either direction, with fixed latency.

---
 rtl/nlc_pkg.sv | 30 +++
 rtl/nlc_lzc20.sv | 22 ++
 rtl/nlc_fmt_converter.sv | 151 +++++++++++++++
 tb/tb_nlc_fmt_converter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/nlc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nlc_pkg : shared widths, constants and pipeline record for NLC       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package nlc_pkg;

  localparam int          SMC_W       = 21;
  localparam int          MAG_W       = 20;
  localparam int          FP_W        = 32;
  localparam int          FP_BIAS     = 127;
  localparam logic [19:0] SMC_MAX_MAG = 20'hFFFFF;
  localparam int          FP_EXP_TOP  = 146;

  // Widest payload is the FP32 decode in S1: {class, exp, mant24}
  localparam int PAY_W = 34;

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_SPEC = 2'd2;

  typedef struct packed {
    logic             valid;
    logic             dir;
    logic             sign;
    logic [PAY_W-1:0] payload;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/nlc_lzc20.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nlc_lzc20 : combinational 20-bit leading-zero counter                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module nlc_lzc20
  import nlc_pkg::*;
(
  input  logic [MAG_W-1:0] i_mag,
  output logic [4:0]       o_lz
);

  // Higher set bits overwrite lower ones, so the MSB wins; zero input gives 0.
  always_comb begin
    o_lz = 5'd0;
    for (int i = 0; i < MAG_W; i++) begin
      if (i_mag[i]) o_lz = 5'(MAG_W - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/nlc_fmt_converter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nlc_fmt_converter : pipelined SMC21 <-> FP32 converter               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module nlc_fmt_converter
  import nlc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              srdyi,
  input  logic              dir_i,
  input  logic [SMC_W-1:0]  smc_i,
  input  logic [FP_W-1:0]   fp_i,
  output logic              srdyo,
  output logic              dir_o,
  output logic [FP_W-1:0]   fp_o,
  output logic [SMC_W-1:0]  smc_o
);

  stage_t r_s1, r_s2, r_s3;

  logic [1:0]       w_cls;
  logic [MAG_W-1:0] w_s1_mag;
  logic [7:0]       w_s1_exp;
  logic [23:0]      w_s1_mant;
  logic [1:0]       w_s1_cls;
  logic [4:0]       w_lz;
  logic signed [9:0] w_e;
  logic [4:0]       w_shamt;
  logic [MAG_W-1:0] w_fp_mag;
  logic [MAG_W-1:0] w_s2_mag;
  logic [4:0]       w_s2_lz;
  logic [MAG_W-1:0] w_norm;
  logic [7:0]       w_exp;
  logic             w_s3_sign;
  logic             w_unused;

  // ---------------- S1: capture and classify ----------------
  always_comb begin
    w_cls = CLS_NORM;
    if (fp_i[30:23] == 8'd0)        w_cls = CLS_ZERO;
    else if (fp_i[30:23] == 8'hFF)  w_cls = CLS_SPEC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1.valid <= 1'b0;
    end else begin
      r_s1.valid <= srdyi;
      if (srdyi) begin
        r_s1.dir <= dir_i;
        if (dir_i) begin
          r_s1.sign    <= fp_i[31];
          r_s1.payload <= {w_cls, fp_i[30:23], 1'b1, fp_i[22:0]};
        end else begin
          r_s1.sign    <= smc_i[SMC_W-1];
          r_s1.payload <= {{(PAY_W-MAG_W){1'b0}}, smc_i[MAG_W-1:0]};
        end
      end
    end
  end

  // ---------------- S2: leading zeros / FP alignment ----------------
  assign w_s1_mag  = r_s1.payload[MAG_W-1:0];
  assign w_s1_mant = r_s1.payload[23:0];
  assign w_s1_exp  = r_s1.payload[31:24];
  assign w_s1_cls  = r_s1.payload[33:32];
  assign w_e       = $signed({2'b00, w_s1_exp}) - 10'sd127;

  nlc_lzc20 u_lzc (
    .i_mag (w_s1_mag),
    .o_lz  (w_lz)
  );

  always_comb begin
    w_fp_mag = '0;
    w_shamt  = 5'd0;
    if (w_s1_cls == CLS_SPEC) begin
      w_fp_mag = SMC_MAX_MAG;
    end else if (w_s1_cls == CLS_NORM) begin
      if (w_e > 10'sd19) begin
        w_fp_mag = SMC_MAX_MAG;
      end else if (w_e >= 10'sd0) begin
        w_shamt  = 5'd23 - w_e[4:0];
        w_fp_mag = MAG_W'(w_s1_mant >> w_shamt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2.valid <= 1'b0;
    end else begin
      r_s2.valid <= r_s1.valid;
      if (r_s1.valid) begin
        r_s2.dir  <= r_s1.dir;
        r_s2.sign <= r_s1.sign;
        if (r_s1.dir) r_s2.payload <= {{(PAY_W-MAG_W){1'b0}}, w_fp_mag};
        else          r_s2.payload <= {{(PAY_W-MAG_W-5){1'b0}}, w_lz, w_s1_mag};
      end
    end
  end

  // ---------------- S3: normalize / pack ----------------
  assign w_s2_mag  = r_s2.payload[MAG_W-1:0];
  assign w_s2_lz   = r_s2.payload[MAG_W+4:MAG_W];
  assign w_norm    = w_s2_mag << w_s2_lz;
  assign w_exp     = 8'(FP_EXP_TOP) - {3'b000, w_s2_lz};
  // A zero magnitude never carries a sign in either format.
  assign w_s3_sign = r_s2.sign & (w_s2_mag != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3.valid <= 1'b0;
    end else begin
      r_s3.valid <= r_s2.valid;
      if (r_s2.valid) begin
        r_s3.dir  <= r_s2.dir;
        r_s3.sign <= w_s3_sign;
        if (r_s2.dir)
          r_s3.payload <= {{(PAY_W-MAG_W){1'b0}}, w_s2_mag};
        else if (w_s2_mag == '0)
          r_s3.payload <= '0;
        else
          r_s3.payload <= {3'b000, w_exp, w_norm[18:0], 4'b0000};
      end
    end
  end

  // ---------------- Output register: only the active bus updates ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      srdyo <= 1'b0;
      dir_o <= 1'b0;
      fp_o  <= '0;
      smc_o <= '0;
    end else begin
      srdyo <= r_s3.valid;
      if (r_s3.valid) begin
        dir_o <= r_s3.dir;
        if (r_s3.dir) smc_o <= {r_s3.sign, r_s3.payload[MAG_W-1:0]};
        else          fp_o  <= {r_s3.sign, r_s3.payload[30:0]};
      end
    end
  end

  assign w_unused = ^{r_s2.payload[PAY_W-1:MAG_W+5], r_s3.payload[PAY_W-1:31]};

endmodule
`default_nettype wire

// File: tb/tb_nlc_fmt_converter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nlc_fmt_converter : directed/table bench for nlc_fmt_converter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_nlc_fmt_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        srdyi = 1'b0;
  logic        dir_i = 1'b0;
  logic [20:0] smc_i = '0;
  logic [31:0] fp_i = '0;
  logic        srdyo;
  logic        dir_o;
  logic [31:0] fp_o;
  logic [20:0] smc_o;

  always #5 clk = ~clk;

  nlc_fmt_converter dut (
    .clk   (clk),
    .rst   (rst),
    .srdyi (srdyi),
    .dir_i (dir_i),
    .smc_i (smc_i),
    .fp_i  (fp_i),
    .srdyo (srdyo),
    .dir_o (dir_o),
    .fp_o  (fp_o),
    .smc_o (smc_o)
  );

  typedef struct {
    logic        dir;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        dir;
    logic [20:0] smc;
    logic [31:0] fp;
    logic [31:0] expv;
  } vec_t;

  exp_t        q[$];
  vec_t        tbl[12];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_fp = '0;
  logic [20:0] m_smc = '0;

  function automatic logic [31:0] m_smc2fp(input logic [20:0] s);
    logic [19:0] m;
    logic [22:0] f;
    int          p;
    m = s[19:0];
    p = 0;
    if (m == 20'd0) return 32'd0;
    for (int i = 0; i < 20; i++) if (m[i]) p = i;
    f = 23'({3'b000, m} << (23 - p));
    return {s[20], 8'(127 + p), f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", name, cyc, act, expv);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (srdyo === 1'b1) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        chk("srdyo_unexpected", {31'd0, srdyo}, 32'd0);
      end else begin
        e = q.pop_front();
        if (e.dir) m_smc = e.val[20:0];
        else       m_fp  = e.val;
        chk("dir_o", {31'd0, dir_o}, {31'd0, e.dir});
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      chk("srdyo_missing", {31'd0, srdyo}, 32'd1);
      e = q.pop_front();
    end
    chk("fp_o", fp_o, m_fp);
    chk("smc_o", {11'd0, smc_o}, {11'd0, m_smc});
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic beat(input logic d, input logic [20:0] s, input logic [31:0] f,
                      input logic [31:0] e, input bit track);
    srdyi = 1'b1;
    dir_i = d;
    smc_i = s;
    fp_i  = f;
    if (track) q.push_back('{d, e, cyc + 4});
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      srdyi = 1'b0;
      dir_i = 1'($urandom);
      smc_i = 21'($urandom);
      fp_i  = $urandom;
      tick();
    end
  endtask

  initial begin
    logic [19:0] mag;
    logic        sg;
    logic [31:0] f;

    tbl[0]  = '{1'b0, 21'h000001, 32'h0,        32'h3F800000};
    tbl[1]  = '{1'b1, 21'h0,      32'h40490FDB, 32'h00000003};
    tbl[2]  = '{1'b0, 21'h100005, 32'h0,        32'hC0A00000};
    tbl[3]  = '{1'b1, 21'h0,      32'hC2C80000, 32'h00100064};
    tbl[4]  = '{1'b0, 21'h0FFFFF, 32'h0,        32'h497FFFF0};
    tbl[5]  = '{1'b1, 21'h0,      32'hBF000000, 32'h00000000};
    tbl[6]  = '{1'b0, 21'h100000, 32'h0,        32'h00000000};
    tbl[7]  = '{1'b1, 21'h0,      32'h4B800000, 32'h000FFFFF};
    tbl[8]  = '{1'b1, 21'h0,      32'hFFC00000, 32'h001FFFFF};
    tbl[9]  = '{1'b1, 21'h0,      32'h00000001, 32'h00000000};
    tbl[10] = '{1'b1, 21'h0,      32'h49800000, 32'h000FFFFF};
    tbl[11] = '{1'b1, 21'h0,      32'h3F800000, 32'h00000001};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_srdyo", {31'd0, srdyo}, 32'd0);
    chk("rst_dir_o", {31'd0, dir_o}, 32'd0);
    chk("rst_fp_o",  fp_o, 32'd0);
    chk("rst_smc_o", {11'd0, smc_o}, 32'd0);
    rst = 1'b0;

    // Directed table, back-to-back with mixed directions
    for (int i = 0; i < 12; i++)
      beat(tbl[i].dir, tbl[i].smc, tbl[i].fp, tbl[i].expv, 1'b1);
    idle(6);

    // 16 consecutive SMC beats
    for (int i = 0; i < 16; i++) begin
      sg  = 1'(i & 1);
      mag = 20'(i * 32'h1111 + 1);
      beat(1'b0, {sg, mag}, 32'h0, m_smc2fp({sg, mag}), 1'b1);
    end
    idle(6);

    // Round trip: SMC -> FP32 then FP32 -> SMC, alternating each cycle
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      mag = 20'd0;
      else if (i == 1) mag = 20'hFFFFF;
      else             mag = 20'($urandom_range(0, 32'hFFFFF));
      sg = 1'($urandom_range(0, 1));
      f  = m_smc2fp({sg, mag});
      beat(1'b0, {sg, mag}, 32'h0, f, 1'b1);
      beat(1'b1, 21'h0, f, {11'd0, (sg & (mag != 20'd0)), mag}, 1'b1);
    end
    idle(6);

    // Reset with beats in flight, plus one beat presented alongside rst
    beat(1'b0, 21'h00000F, 32'h0, 32'h0, 1'b0);
    beat(1'b1, 21'h0, 32'h42000000, 32'h0, 1'b0);
    beat(1'b0, 21'h1ABCDE, 32'h0, 32'h0, 1'b0);
    rst   = 1'b1;
    srdyi = 1'b1;
    dir_i = 1'b1;
    fp_i  = 32'h41200000;
    @(posedge clk);
    cyc++;
    m_fp  = '0;
    m_smc = '0;
    @(negedge clk);
    monitor();
    rst = 1'b0;
    idle(8);
    chk("post_rst_srdyo", {31'd0, srdyo}, 32'd0);
    chk("post_rst_dir_o", {31'd0, dir_o}, 32'd0);
    chk("post_rst_fp_o",  fp_o, 32'd0);
    chk("post_rst_smc_o", {11'd0, smc_o}, 32'd0);
    chk("drain", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
